// File: rtl/lowampa_capture_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lowampa_capture_ctrl
//
// Sequences capture windows for the lowampa buffer path. A window is:
//   IDLE -> PRE (pretrigger fill) -> ARMED (wait for a qualified hit)
//        -> POST (posttrigger fill) -> READ (wait for the buffer to be read
//        out) -> HOLD (dead time) -> PRE (continuous) or IDLE.
// The block qualifies the per-beam trigger vector with a beam mask, emits a
// one-cycle capture-aligned trigger pulse, and keeps trigger and lost-trigger
// statistics for readout.
//
// Optional feature (macro LOWAMPA_CAPTURE_TIMESTAMP_EN):
//   defined   - a free-running 48-bit cycle counter is built and trig_time_o
//               latches its value for the hit cycle of each accepted trigger.
//   undefined - no counter is built and trig_time_o is tied to 0.
//
// Ports:
//   aclk             datapath clock, all logic on the rising edge
//   aresetn          synchronous active-low reset
//   arm_i            single-cycle arm request (honoured only in IDLE)
//   disarm_i         single-cycle abort, highest priority
//   continuous_i     1 = re-arm automatically after holdoff
//   clr_counts_i     zeros trig_count_o and lost_count_o
//   pretrig_len_i    pretrigger fill length in cycles (0 acts as 1)
//   posttrig_len_i   posttrigger length in cycles (0 acts as 1)
//   holdoff_len_i    dead time after readout in cycles (0 acts as 1)
//   beam_trig_i      per-beam trigger flags
//   beam_mask_i      per-beam enables, 1 = beam participates
//   sw_trig_i        software trigger
//   capture_waiting  buffer is idle / read out and ready for a new capture
//   capture_enable   buffer write enable
//   trigger          one-cycle pulse per accepted trigger
//   trig_beams_o     masked beam pattern of the last accepted trigger
//   trig_count_o     accepted trigger count, wraps
//   lost_count_o     hits seen in POST/READ/HOLD, saturating
//   state_o          current state encoding
//   trig_time_o      timestamp of the last accepted trigger
// -----------------------------------------------------------------------------
module lowampa_capture_ctrl #(
  parameter int NBEAMS = 54,
  parameter int CNT_W  = 12,
  parameter int LOST_W = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              arm_i,
  input  logic              disarm_i,
  input  logic              continuous_i,
  input  logic              clr_counts_i,
  input  logic [CNT_W-1:0]  pretrig_len_i,
  input  logic [CNT_W-1:0]  posttrig_len_i,
  input  logic [CNT_W-1:0]  holdoff_len_i,
  input  logic [NBEAMS-1:0] beam_trig_i,
  input  logic [NBEAMS-1:0] beam_mask_i,
  input  logic              sw_trig_i,
  input  logic              capture_waiting,
  output logic              capture_enable,
  output logic              trigger,
  output logic [NBEAMS-1:0] trig_beams_o,
  output logic [31:0]       trig_count_o,
  output logic [LOST_W-1:0] lost_count_o,
  output logic [2:0]        state_o,
  output logic [47:0]       trig_time_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_ARMED = 3'd2,
    ST_POST  = 3'd3,
    ST_READ  = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // The window counter holds "cycles remaining minus one", so a state is left
  // on the cycle the counter reads zero. Loading len-1 (or 0 for len 0) gives
  // exactly max(len,1) cycles in the state.
  function automatic logic [CNT_W-1:0] win_load(input logic [CNT_W-1:0] len);
    return (len == '0) ? '0 : len - CNT_W'(1);
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               arm_pend_q, arm_pend_d;
  logic               seen_low_q, seen_low_d;

  logic [NBEAMS-1:0]  hit_beams;
  logic               hit;
  logic               win_done;
  logic               accept;
  logic               lost_inc;

  logic               cap_en_d;
  logic [NBEAMS-1:0]  trig_beams_d;
  logic [31:0]        trig_count_d;
  logic [LOST_W-1:0]  lost_count_d;

  assign hit_beams = beam_trig_i & beam_mask_i;
  assign hit       = (|hit_beams) | sw_trig_i;
  assign win_done  = (cnt_q == '0);

  // A trigger is accepted only while ARMED; disarm suppresses it outright.
  assign accept    = (state_q == ST_ARMED) && hit && !disarm_i;

  // ---------------------------------------------------------------------------
  // State register (with the FSM's auxiliary state)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of process ordering.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      arm_pend_q <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      arm_pend_q <= arm_pend_d;
      seen_low_q <= seen_low_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold-value default first, so no path
  // through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    arm_pend_d = arm_pend_q;
    seen_low_d = seen_low_q;

    if (disarm_i) begin
      state_d    = ST_IDLE;
      arm_pend_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // An arm in the same cycle as capture_waiting starts immediately;
          // otherwise it is remembered until the buffer reports ready.
          if ((arm_pend_q || arm_i) && capture_waiting) begin
            state_d    = ST_PRE;
            arm_pend_d = 1'b0;
            cnt_d      = win_load(pretrig_len_i);
          end else if (arm_i) begin
            arm_pend_d = 1'b1;
          end
        end

        ST_PRE: begin
          if (win_done) state_d = ST_ARMED;
          else          cnt_d   = cnt_q - CNT_W'(1);
        end

        ST_ARMED: begin
          if (hit) begin
            state_d = ST_POST;
            cnt_d   = win_load(posttrig_len_i);
          end
        end

        ST_POST: begin
          if (win_done) begin
            state_d    = ST_READ;
            seen_low_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        ST_READ: begin
          // Leave only on a low-then-high of capture_waiting seen inside READ,
          // so a level that is still high from before readout is not taken as
          // "read out".
          if (!capture_waiting) begin
            seen_low_d = 1'b1;
          end else if (seen_low_q) begin
            state_d = ST_HOLD;
            cnt_d   = win_load(holdoff_len_i);
          end
        end

        ST_HOLD: begin
          if (win_done) begin
            if (continuous_i) begin
              state_d = ST_PRE;
              cnt_d   = win_load(pretrig_len_i);
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (next values of the registered outputs)
  // ---------------------------------------------------------------------------
  always_comb begin
    // Write enable trails the state by one cycle: high from the cycle after
    // PRE entry through the cycle after the last POST cycle, so its high time
    // equals the number of cycles spent in PRE, ARMED and POST.
    cap_en_d = !disarm_i && (state_q inside {ST_PRE, ST_ARMED, ST_POST});

    trig_beams_d = accept ? hit_beams : trig_beams_o;

    lost_inc = hit && !disarm_i
             && (state_q inside {ST_POST, ST_READ, ST_HOLD})
             && !(&lost_count_o);

    // Clearing wins over a coincident increment.
    if (clr_counts_i) begin
      trig_count_d = '0;
      lost_count_d = '0;
    end else begin
      trig_count_d = accept   ? trig_count_o + 32'd1       : trig_count_o;
      lost_count_d = lost_inc ? lost_count_o + LOST_W'(1)  : lost_count_o;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      capture_enable <= 1'b0;
      trigger        <= 1'b0;
      trig_beams_o   <= '0;
      trig_count_o   <= '0;
      lost_count_o   <= '0;
    end else begin
      capture_enable <= cap_en_d;
      trigger        <= accept;
      trig_beams_o   <= trig_beams_d;
      trig_count_o   <= trig_count_d;
      lost_count_o   <= lost_count_d;
    end
  end

  // state_q is itself a register, so state_o is registered.
  assign state_o = state_q;

  // ---------------------------------------------------------------------------
  // Optional trigger timestamp
  // ---------------------------------------------------------------------------
`ifdef LOWAMPA_CAPTURE_TIMESTAMP_EN
  logic [47:0] ts_q;

  // trig_time_o takes the counter value of the hit cycle, so it updates on the
  // same edge that raises trigger.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ts_q        <= '0;
      trig_time_o <= '0;
    end else begin
      ts_q <= ts_q + 48'd1;
      if (accept) trig_time_o <= ts_q;
    end
  end
`else
  assign trig_time_o = '0;
`endif

endmodule
